// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game-flow FSM (IDLE/SERVE/PLAY/OVER) with serve timer and binary+BCD scoring.
// Optional paddle-hit rally counter is built only when RALLY_CNT_EN is defined.
module pong_game_ctrl #(
  parameter int WIN_SCORE          = 7,
  parameter int SERVE_DELAY_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       start_btn,
  input  logic       l_win,
  input  logic       r_win,
  input  logic       hit,
  output logic       gra_still,
  output logic [7:0] l_score_bcd,
  output logic [7:0] r_score_bcd,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] state,
  output logic [7:0] rally_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERVE = 2'b01,
    PLAY  = 2'b10,
    OVER  = 2'b11
  } state_t;

  localparam logic [6:0] WIN_B     = 7'(WIN_SCORE);
  localparam logic [9:0] DELAY_B   = 10'(SERVE_DELAY_FRAMES);
  localparam logic [6:0] SCORE_MAX = 7'd99;

  state_t     state_q;
  logic [9:0] timer_q;
  logic [6:0] l_bin_q, r_bin_q;
  logic [7:0] l_bcd_q, r_bcd_q;
  logic       winner_q;
  logic [2:0] btn_sync_q;

  logic       frame_tick;
  logic       start_pulse;
  logic [6:0] l_bin_d, r_bin_d;
  logic [7:0] l_bcd_d, r_bcd_d;

  function automatic logic [6:0] bin_inc(input logic [6:0] b);
    return (b >= SCORE_MAX) ? SCORE_MAX : b + 7'd1;
  endfunction

  // Two-digit BCD increment, sticking at 99 to match the binary counter.
  function automatic logic [7:0] bcd_inc(input logic [7:0] b);
    if (b == 8'h99) return b;
    if (b[3:0] == 4'd9) return {b[7:4] + 4'd1, 4'd0};
    return {b[7:4], b[3:0] + 4'd1};
  endfunction

  assign frame_tick  = (pix_y == 10'd481) && (pix_x == 10'd0);
  assign start_pulse = btn_sync_q[1] & ~btn_sync_q[2];

  assign l_bin_d = bin_inc(l_bin_q);
  assign r_bin_d = bin_inc(r_bin_q);
  assign l_bcd_d = bcd_inc(l_bcd_q);
  assign r_bcd_d = bcd_inc(r_bcd_q);

  assign gra_still   = (state_q != PLAY);
  assign game_over   = (state_q == OVER);
  assign state       = state_q;
  assign winner      = winner_q;
  assign l_score_bcd = l_bcd_q;
  assign r_score_bcd = r_bcd_q;

  // Bits [1:0] synchronise the raw button; bit [2] is the edge-detect history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) btn_sync_q <= 3'b000;
    else       btn_sync_q <= {btn_sync_q[1:0], start_btn};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      l_bin_q  <= '0;
      r_bin_q  <= '0;
      l_bcd_q  <= '0;
      r_bcd_q  <= '0;
      winner_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, OVER: begin
          if (start_pulse) begin
            l_bin_q  <= '0;
            r_bin_q  <= '0;
            l_bcd_q  <= '0;
            r_bcd_q  <= '0;
            winner_q <= 1'b0;
            timer_q  <= DELAY_B;
            state_q  <= SERVE;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            timer_q <= timer_q - 10'd1;
            if (timer_q == 10'd1) state_q <= PLAY;
          end
        end
        PLAY: begin
          // Left has priority when both borders report in the same cycle.
          if (l_win) begin
            l_bin_q <= l_bin_d;
            l_bcd_q <= l_bcd_d;
            if (l_bin_d == WIN_B) begin
              winner_q <= 1'b0;
              state_q  <= OVER;
            end else begin
              timer_q <= DELAY_B;
              state_q <= SERVE;
            end
          end else if (r_win) begin
            r_bin_q <= r_bin_d;
            r_bcd_q <= r_bcd_d;
            if (r_bin_d == WIN_B) begin
              winner_q <= 1'b1;
              state_q  <= OVER;
            end else begin
              timer_q <= DELAY_B;
              state_q <= SERVE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RALLY_CNT_EN
  logic       hit_q;
  logic [7:0] rally_q;
  logic       to_serve;

  // Mirrors every FSM branch that lands in SERVE so the count clears on that same edge.
  assign to_serve = (((state_q == IDLE) || (state_q == OVER)) && start_pulse) ||
                    ((state_q == PLAY) &&
                     ((l_win && (l_bin_d != WIN_B)) || (!l_win && r_win && (r_bin_d != WIN_B))));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q   <= 1'b0;
      rally_q <= '0;
    end else begin
      hit_q <= hit;
      if (to_serve)
        rally_q <= '0;
      else if ((state_q == PLAY) && hit && !hit_q && (rally_q != 8'hFF))
        rally_q <= rally_q + 8'd1;
    end
  end

  assign rally_cnt = rally_q;
`else
  logic unused_hit;
  assign unused_hit = hit;
  assign rally_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed and randomized checks of pong_game_ctrl against a score/state model.
// Instance 0 uses WIN_SCORE=3, instance 1 uses WIN_SCORE=12 (BCD carry); both SERVE_DELAY_FRAMES=2.
`timescale 1ns/1ps
module tb_pong_game_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Decimated 800x525 raster: every 200th column and every 37th row, so row 481 col 0 still occurs.
  logic [9:0] pix_x = 10'd0;
  logic [9:0] pix_y = 10'd0;
  always @(posedge clk) begin
    if (pix_x == 10'd600) begin
      pix_x <= 10'd0;
      pix_y <= (pix_y >= 10'd518) ? 10'd0 : pix_y + 10'd37;
    end else begin
      pix_x <= pix_x + 10'd200;
    end
  end

  logic [1:0] rst, btn, lw, rw, ht;
  logic [1:0] gs, go, wn;
  logic [7:0] lsc [2];
  logic [7:0] rsc [2];
  logic [1:0] st  [2];
  logic [7:0] ral [2];

  pong_game_ctrl #(.WIN_SCORE(3), .SERVE_DELAY_FRAMES(2)) dut0 (
    .clk(clk), .reset(rst[0]), .pix_x(pix_x), .pix_y(pix_y),
    .start_btn(btn[0]), .l_win(lw[0]), .r_win(rw[0]), .hit(ht[0]),
    .gra_still(gs[0]), .l_score_bcd(lsc[0]), .r_score_bcd(rsc[0]),
    .game_over(go[0]), .winner(wn[0]), .state(st[0]), .rally_cnt(ral[0])
  );

  pong_game_ctrl #(.WIN_SCORE(12), .SERVE_DELAY_FRAMES(2)) dut1 (
    .clk(clk), .reset(rst[1]), .pix_x(pix_x), .pix_y(pix_y),
    .start_btn(btn[1]), .l_win(lw[1]), .r_win(rw[1]), .hit(ht[1]),
    .gra_still(gs[1]), .l_score_bcd(lsc[1]), .r_score_bcd(rsc[1]),
    .game_over(go[1]), .winner(wn[1]), .state(st[1]), .rally_cnt(ral[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  function automatic logic [7:0] exp_rally(input int n);
`ifdef RALLY_CNT_EN
    return 8'((n > 255) ? 255 : n);
`else
    return 8'(0 * n);
`endif
  endfunction

  task automatic wait_state(input int d, input logic [1:0] exp, input int budget, input string tag);
    for (int i = 0; i < budget && st[d] != exp; i++) @(negedge clk);
    check(tag, 8'(st[d]), 8'(exp));
  endtask

  // From SERVE: count frame ticks seen by the DUT; PLAY must arrive exactly with the 2nd one.
  task automatic serve_to_play(input int d, input string tag);
    int ticks;
    bit tk;
    bit early;
    ticks = 0;
    early = 1'b0;
    for (int i = 0; i < 400 && ticks < 2; i++) begin
      tk = (pix_y == 10'd481) && (pix_x == 10'd0);
      @(negedge clk);
      if (tk) ticks++;
      if (ticks < 2 && st[d] != 2'b01) early = 1'b1;
    end
    check({tag, "_early"}, 8'(early), 8'h00);
    check({tag, "_play"}, 8'(st[d]), 8'h02);
  endtask

  task automatic pulses(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      ht[d] = 1'b1;
      cyc(1 + int'($urandom_range(0, 1)));
      ht[d] = 1'b0;
      cyc(1 + int'($urandom_range(0, 1)));
    end
    cyc(1);
  endtask

  int ml, mr, ev, nh;

  initial begin
    rst = 2'b11; btn = '0; lw = '0; rw = '0; ht = '0;
    cyc(3);
    check("rst_state", 8'(st[0]), 8'h00);
    check("rst_gra_still", 8'(gs[0]), 8'h01);
    check("rst_l_score", lsc[0], 8'h00);
    check("rst_r_score", rsc[0], 8'h00);
    check("rst_game_over", 8'(go[0]), 8'h00);
    check("rst_winner", 8'(wn[0]), 8'h00);
    check("rst_rally", ral[0], 8'h00);
    rst = 2'b00;
    cyc(2);
    check("idle_hold", 8'(st[0]), 8'h00);

    // Start held high: SERVE within 3 clocks, then PLAY on the 2nd frame tick.
    btn[0] = 1'b1;
    wait_state(0, 2'b01, 3, "start_to_serve");
    check("serve_gra_still", 8'(gs[0]), 8'h01);
    serve_to_play(0, "serve1");
    check("play_gra_still", 8'(gs[0]), 8'h00);
    btn[0] = 1'b0;

    lw[0] = 1'b1; cyc(20); lw[0] = 1'b0; cyc(1);
    check("lwin_hold_l", lsc[0], 8'h01);
    check("lwin_hold_state", 8'(st[0]), 8'h01);
    check("lwin_hold_r", rsc[0], 8'h00);
    serve_to_play(0, "serve2");

    for (int k = 1; k <= 3; k++) begin
      rw[0] = 1'b1; cyc(5); rw[0] = 1'b0; cyc(1);
      check("rwin_r_score", rsc[0], to_bcd(k));
      if (k < 3) begin
        check("rwin_state", 8'(st[0]), 8'h01);
        serve_to_play(0, "serve_r");
      end
    end
    check("over_state", 8'(st[0]), 8'h03);
    check("over_game_over", 8'(go[0]), 8'h01);
    check("over_winner", 8'(wn[0]), 8'h01);
    check("over_gra_still", 8'(gs[0]), 8'h01);
    check("over_l_score", lsc[0], 8'h01);
    rw[0] = 1'b1; cyc(5); rw[0] = 1'b0; cyc(1);
    check("over_r_hold", rsc[0], 8'h03);
    check("over_state_hold", 8'(st[0]), 8'h03);

    btn[0] = 1'b1;
    wait_state(0, 2'b01, 4, "restart_serve");
    btn[0] = 1'b0;
    check("restart_l", lsc[0], 8'h00);
    check("restart_r", rsc[0], 8'h00);
    check("restart_winner", 8'(wn[0]), 8'h00);
    check("restart_game_over", 8'(go[0]), 8'h00);
    serve_to_play(0, "serve3");

    pulses(0, 5);
    check("rally_5", ral[0], exp_rally(5));
    lw[0] = 1'b1; rw[0] = 1'b1; cyc(3); lw[0] = 1'b0; rw[0] = 1'b0; cyc(1);
    check("both_l", lsc[0], 8'h01);
    check("both_r", rsc[0], 8'h00);
    check("both_state", 8'(st[0]), 8'h01);
    check("rally_clear", ral[0], 8'h00);

    // Reset mid-SERVE must act before the next clock edge.
    cyc(3);
    check("pre_reset_state", 8'(st[0]), 8'h01);
    #2 rst[0] = 1'b1;
    #1;
    check("async_rst_state", 8'(st[0]), 8'h00);
    check("async_rst_l", lsc[0], 8'h00);
    check("async_rst_gra", 8'(gs[0]), 8'h01);
    cyc(1);
    rst[0] = 1'b0;
    cyc(1);

    // BCD carry on the WIN_SCORE=12 instance.
    btn[1] = 1'b1;
    wait_state(1, 2'b01, 4, "b_start");
    btn[1] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      serve_to_play(1, "b_serve");
      lw[1] = 1'b1; cyc(3); lw[1] = 1'b0; cyc(1);
    end
    check("bcd_carry", lsc[1], 8'h10);
    check("bcd_state", 8'(st[1]), 8'h01);

    // Randomized rounds against the score model.
    ml = 0; mr = 0;
    btn[0] = 1'b1;
    wait_state(0, 2'b01, 4, "rnd_start");
    btn[0] = 1'b0;
    for (int r = 0; r < 20; r++) begin
      serve_to_play(0, "rnd_serve");
      cyc(int'($urandom_range(0, 10)));
      nh = int'($urandom_range(0, 6));
      pulses(0, nh);
      check("rnd_rally", ral[0], exp_rally(nh));
      ev = int'($urandom_range(0, 2));
      lw[0] = (ev != 1);
      rw[0] = (ev != 0);
      cyc(int'($urandom_range(1, 20)));
      lw[0] = 1'b0; rw[0] = 1'b0;
      cyc(1);
      if (ev != 1) ml++;
      else mr++;
      check("rnd_l", lsc[0], to_bcd(ml));
      check("rnd_r", rsc[0], to_bcd(mr));
      if (ml == 3 || mr == 3) begin
        check("rnd_over", 8'(st[0]), 8'h03);
        check("rnd_winner", 8'(wn[0]), 8'(mr == 3));
        check("rnd_rally_hold", ral[0], exp_rally(nh));
        btn[0] = 1'b1;
        wait_state(0, 2'b01, 4, "rnd_restart");
        btn[0] = 1'b0;
        ml = 0; mr = 0;
        check("rnd_restart_l", lsc[0], 8'h00);
        check("rnd_restart_r", rsc[0], 8'h00);
      end else begin
        check("rnd_serve_state", 8'(st[0]), 8'h01);
        check("rnd_rally_clr", ral[0], 8'h00);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Game-flow controller sitting directly downstream of the pong graphics/physics block.
- Consumes that block's l_win, r_win and hit status and produces its gra_still input.
- Sequences new game, serve delay, play and game over; keeps both players' scores, in binary and BCD for the score display.
- Frame timing is derived from the same pix_x/pix_y counters the graphics block uses.

Parameters:
- WIN_SCORE, 7, points needed to win; legal range 1..99.
- SERVE_DELAY_FRAMES, 120, frame ticks spent frozen before each serve (2 s at 60 Hz); legal range 1..1023.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- pix_x  input  10  current pixel column from the VGA sync generator
- pix_y  input  10  current pixel row from the VGA sync generator
- start_btn  input  1  raw, asynchronous start button
- l_win  input  1  level; left player scored (ball at right border)
- r_win  input  1  level; right player scored (ball at left border)
- hit  input  1  level; ball overlapping a paddle
- gra_still  output  1  freeze/re-centre ball and paddles
- l_score_bcd  output  8  left score as two BCD digits {tens,units}
- r_score_bcd  output  8  right score as two BCD digits
- game_over  output  1  high in OVER state
- winner  output  1  0 = left won, 1 = right won; valid while game_over = 1
- state  output  2  IDLE=00, SERVE=01, PLAY=10, OVER=11
- rally_cnt  output  8  paddle hits in current rally (see Optional Feature)

Behaviour:
- Reset values: state IDLE; both scores 0 (binary and BCD); gra_still 1; game_over 0; winner 0; rally_cnt 0; serve timer 0.
- frame_tick: combinational, (pix_y == 481) && (pix_x == 0). Identical to the tick the graphics block uses to move objects.
- start_btn path: 2-flop synchroniser, then a rising-edge detector producing a 1-clk start_pulse. State changes on the clk edge where start_pulse is 1.
  - Holding the button high produces no further pulses.
- gra_still: Moore output, 1 in every state except PLAY.
- game_over: 1 only in OVER.
- IDLE:
  - On start_pulse: clear scores, load timer with SERVE_DELAY_FRAMES, go to SERVE.
- SERVE:
  - On each frame_tick: decrement the timer.
  - On a frame_tick with timer == 1: go to PLAY (timer reaches 0).
  - Ignore l_win, r_win and start_pulse.
- PLAY:
  - l_win and r_win are levels held for several cycles. They are sampled only in PLAY, so each border event is counted exactly once: the transition out of PLAY raises gra_still, which re-centres the ball.
  - l_win = 1: left score +1.
  - r_win = 1: right score +1.
  - Both 1 in the same cycle: only l_win is scored (left priority).
  - After a score:
    - If the new binary score == WIN_SCORE: go to OVER, winner = scoring side.
    - Otherwise: reload timer, go to SERVE.
  - start_pulse is ignored in PLAY.
- OVER:
  - Scores and winner hold.
  - On start_pulse: clear scores and winner, reload timer, go to SERVE.
- Score arithmetic:
  - 7-bit binary counter per side.
  - BCD pair updated in the same clk edge; units 9 -> 0 with a carry into tens.
  - Saturate at 99 (unreachable when WIN_SCORE <= 99, but required).
- Reset mid-game (any state, any cycle): immediately returns all registers to their reset values.
- All outputs are registered except gra_still and game_over, which decode the state register.

Optional Feature:
- Macro RALLY_CNT_EN.
- Defined:
  - hit is registered; each 0 -> 1 transition of hit in PLAY increments rally_cnt, saturating at 255.
  - rally_cnt clears on every entry to SERVE and on reset.
  - rally_cnt holds its value in OVER.
- Not defined: rally_cnt is constant 0 and no hit registers are synthesised.

Test Plan:
- Bench parameters: WIN_SCORE=3, SERVE_DELAY_FRAMES=2, pix counters from a 640x480 VGA model.
- Reset then start_btn pulse -> state 00 -> 01 within 3 clk; gra_still=1; state=10 on the 2nd frame_tick; gra_still=0 the same cycle.
- In PLAY, hold l_win high for 20 clk -> l_score_bcd = 0x01 exactly once; state=01; r_score unchanged.
- Drive 3 r_win events separated by serves -> r_score_bcd 0x03; state=11; game_over=1; winner=1. Further r_win pulses leave the score unchanged. A start pulse then gives scores 0x00 and state 01.
- With WIN_SCORE=12, 10 l_win events -> l_score_bcd = 0x10 (BCD carry check).
- l_win and r_win asserted in the same cycle in PLAY -> left +1, right unchanged. Assert reset mid-SERVE -> state=00 and scores 0 asynchronously, before the next clk edge.
- With RALLY_CNT_EN defined, 5 separate hit pulses in PLAY -> rally_cnt=5; after the next l_win, rally_cnt=0 in SERVE. Without the macro, rally_cnt stays 0.
